// File: rtl/untrusted_device_arbiter.sv
// ---------------------------------------------------------------------------
// untrusted_device_arbiter
//
// Shares the single request/response port of an untrusted device between
// two hosts (host 0: core data port, host 1: DMA). Round-robin arbitration
// with one outstanding transaction. Accesses are checked against the ROM
// and RAM windows. ROM writes and accesses that hit neither window are
// answered locally with an error and never reach the device. A watchdog
// forces an error response if the device stops answering.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_i/gnt_o         per-host request / one-hot grant (grant only in IDLE)
//   we_i/addr_i/wdata_i/be_i  per-host transaction fields (host k in slice k)
//   rvalid_o            per-host one-cycle response strobe
//   rdata_o/err_o       shared response data / error, valid with rvalid_o
//   dev_*               request/response port towards the untrusted device
//   deny_cnt_o          saturating count of locally denied accesses
// ---------------------------------------------------------------------------
module untrusted_device_arbiter #(
   parameter logic [31:0] RomBase       = 32'h00000000,
   parameter logic [31:0] RomMask       = 32'h00003fff,
   parameter logic [31:0] RamBase       = 32'h50000000,
   parameter logic [31:0] RamMask       = 32'h0001ffff,
   parameter logic [15:0] TimeoutCycles = 16'd255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [1:0]  req_i,
   output logic [1:0]  gnt_o,
   input  logic [1:0]  we_i,
   input  logic [63:0] addr_i,
   input  logic [63:0] wdata_i,
   input  logic [7:0]  be_i,
   output logic [1:0]  rvalid_o,
   output logic [31:0] rdata_o,
   output logic        err_o,
   output logic        dev_req_o,
   input  logic        dev_gnt_i,
   output logic        dev_we_o,
   output logic [31:0] dev_addr_o,
   output logic [31:0] dev_wdata_o,
   output logic [3:0]  dev_be_o,
   input  logic        dev_rvalid_i,
   input  logic [31:0] dev_rdata_i,
   input  logic        dev_err_i,
   output logic [15:0] deny_cnt_o
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   logic [1:0]  state_q,      state_d;
   logic        prio_q,       prio_d;
   logic        owner_q,      owner_d;
   logic        we_q,         we_d;
   logic [31:0] addr_q,       addr_d;
   logic [31:0] wdata_q,      wdata_d;
   logic [3:0]  be_q,         be_d;
   logic [15:0] timer_q,      timer_d;
   logic        resp_err_q,   resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic [15:0] deny_cnt_q,   deny_cnt_d;

   logic        winner;
   logic        win_we;
   logic [31:0] win_addr;
   logic [31:0] win_wdata;
   logic [3:0]  win_be;

   // Reads are allowed in both windows, writes only in the RAM window.
   function automatic logic access_allowed(input logic [31:0] addr, input logic we);
      logic rom_hit;
      logic ram_hit;
      rom_hit = (addr & ~RomMask) == RomBase;
      ram_hit = (addr & ~RamMask) == RamBase;
      return ram_hit | (rom_hit & ~we);
   endfunction

   // The host pointed to by prio_q wins if it requests; otherwise the other
   // host wins (only meaningful when at least one host requests).
   always_comb begin
      winner = prio_q;
      if (!req_i[prio_q]) begin
         winner = ~prio_q;
      end
   end

   assign win_we    = winner ? we_i[1]         : we_i[0];
   assign win_addr  = winner ? addr_i[63:32]   : addr_i[31:0];
   assign win_wdata = winner ? wdata_i[63:32]  : wdata_i[31:0];
   assign win_be    = winner ? be_i[7:4]       : be_i[3:0];

   always_comb begin
      state_d      = state_q;
      prio_d       = prio_q;
      owner_d      = owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      timer_d      = timer_q;
      resp_err_d   = resp_err_q;
      resp_rdata_d = resp_rdata_q;
      deny_cnt_d   = deny_cnt_q;
      gnt_o        = 2'b00;

      case (state_q)
         IDLE: begin
            if (|req_i) begin
               gnt_o[winner] = 1'b1;
               owner_d       = winner;
               we_d          = win_we;
               addr_d        = win_addr;
               wdata_d       = win_wdata;
               be_d          = win_be;
               prio_d        = ~winner;
               if (access_allowed(win_addr, win_we)) begin
                  state_d = ISSUE;
               end else begin
                  state_d      = RESP;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'h0;
                  if (deny_cnt_q != 16'hffff) begin
                     deny_cnt_d = deny_cnt_q + 16'd1;
                  end
               end
            end
         end

         ISSUE: begin
            // Waiting for the device to accept is not bounded by the watchdog.
            if (dev_gnt_i) begin
               state_d = WAIT;
               timer_d = 16'h0;
            end
         end

         WAIT: begin
            if (dev_rvalid_i) begin
               state_d      = RESP;
               resp_rdata_d = dev_rdata_i;
               resp_err_d   = dev_err_i;
            end else begin
               timer_d = timer_q + 16'd1;
               if (timer_q + 16'd1 == TimeoutCycles) begin
                  state_d      = RESP;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = 32'h0;
               end
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         prio_q       <= 1'b0;
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         be_q         <= 4'h0;
         timer_q      <= 16'h0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'h0;
         deny_cnt_q   <= 16'h0;
      end else begin
         state_q      <= state_d;
         prio_q       <= prio_d;
         owner_q      <= owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         timer_q      <= timer_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         deny_cnt_q   <= deny_cnt_d;
      end
   end

   // Device fields come straight from the latched transaction so they stay
   // stable for the whole ISSUE phase.
   assign dev_req_o   = (state_q == ISSUE);
   assign dev_we_o    = we_q;
   assign dev_addr_o  = addr_q;
   assign dev_wdata_o = wdata_q;
   assign dev_be_o    = be_q;

   assign rvalid_o    = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign rdata_o     = (state_q == RESP) ? resp_rdata_q : 32'h0;
   assign err_o       = (state_q == RESP) ? resp_err_q : 1'b0;
   assign deny_cnt_o  = deny_cnt_q;

endmodule

// File: doc/untrusted_device_arbiter.md
Name: untrusted_device_arbiter

Overview:
- Shares the single request/response port of the untrusted device between two hosts (host 0: core data port, host 1: DMA).
- Round-robin arbitration, one outstanding transaction at a time.
- Enforces access control on the ROM and RAM windows: writes to ROM and accesses outside both windows are denied locally and never reach the device.
- A watchdog returns an error if the device does not respond.

Parameters:
- RomBase, 32'h00000000, base address of the untrusted ROM window.
- RomMask, 32'h00003fff, offset mask of the ROM window.
- RamBase, 32'h50000000, base address of the untrusted RAM window.
- RamMask, 32'h0001ffff, offset mask of the RAM window.
- TimeoutCycles, 16'd255, maximum WAIT cycles before an error response is forced.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_i  in  2  per-host request; held until gnt_o.
- gnt_o  out  2  per-host grant; one-hot or zero.
- we_i  in  2  per-host write enable.
- addr_i  in  2x32  per-host byte address; host k at bits [32k+31:32k].
- wdata_i  in  2x32  per-host write data.
- be_i  in  2x4  per-host byte enables.
- rvalid_o  out  2  per-host response valid; one-cycle pulse.
- rdata_o  out  32  response data, shared; valid with rvalid_o.
- err_o  out  1  response error, shared; valid with rvalid_o.
- dev_req_o  out  1  device request.
- dev_gnt_i  in  1  device grant.
- dev_we_o  out  1  device write enable.
- dev_addr_o  out  32  device address.
- dev_wdata_o  out  32  device write data.
- dev_be_o  out  4  device byte enables.
- dev_rvalid_i  in  1  device response valid.
- dev_rdata_i  in  32  device read data.
- dev_err_i  in  1  device error.
- deny_cnt_o  out  16  saturating count of denied accesses.

Behaviour:
- Decode:
  - rom_hit = (addr & ~RomMask) == RomBase.
  - ram_hit = (addr & ~RamMask) == RamBase.
  - allow = ram_hit | (rom_hit & ~we).
- FSM states: IDLE, ISSUE, WAIT, RESP. Reset: IDLE; all outputs 0; prio_q=0; deny_cnt_o=0; owner/latched fields 0.
- IDLE:
  - If any req_i is set, winner = the requester at prio_q if it requests, else the other.
  - gnt_o[winner]=1 combinationally this cycle.
  - Latch owner, we, addr, wdata, be; prio_q <= ~winner.
  - If allow: next state ISSUE.
  - Else: next state RESP with resp_err=1, resp_rdata=0, and deny_cnt increments (saturates at 16'hffff).
- ISSUE: dev_req_o=1 and dev_* driven from the latched fields, held stable. On dev_gnt_i: next state WAIT, timer cleared. No timeout in ISSUE.
- WAIT:
  - On dev_rvalid_i: capture dev_rdata_i/dev_err_i, next state RESP.
  - Otherwise the timer increments. When it reaches TimeoutCycles: next state RESP with resp_err=1, resp_rdata=0.
- RESP:
  - rvalid_o[owner]=1, rdata_o=resp_rdata, err_o=resp_err for exactly one cycle, then IDLE.
  - rdata_o for writes is the device data (don't-care for hosts).
- Outside RESP, rvalid_o=0, rdata_o=0, err_o=0.
- dev_rvalid_i in any state other than WAIT is discarded (late response after a timeout).
- Latency: a denied access gets rvalid in the cycle after grant. An allowed access with immediate dev_gnt_i and next-cycle dev_rvalid_i gets rvalid 3 cycles after grant.
- Simultaneous requests alternate strictly. A host that keeps requesting is never granted twice in a row while the other host waits.
- Host request signals are ignored outside IDLE; gnt_o is 0 in ISSUE/WAIT/RESP.
- Asynchronous reset mid-transaction returns to IDLE immediately, drops dev_req_o, and emits no response.

Test Plan:
- Host0 read 0x00000100, device gnt at once, rvalid next cycle with rdata 0xdeadbeef -> dev_addr_o=0x00000100; rvalid_o=2'b01, rdata_o=0xdeadbeef, err_o=0, 3 cycles after gnt_o.
- Host1 write 0x00000010 (ROM) -> dev_req_o stays 0; rvalid_o=2'b10, err_o=1 one cycle after grant; deny_cnt_o=1.
- Host0 read 0x40000000 (no window) -> denied, err_o=1. Host0 write 0x5001fffc -> forwarded with dev_we_o=1. Host0 write 0x50020000 -> denied.
- Both hosts request continuously for 4 transactions from reset -> grant order 0,1,0,1.
- Device never asserts dev_rvalid_i after dev_gnt_i -> err_o=1 after 255 WAIT cycles. A later dev_rvalid_i while IDLE is ignored: no rvalid_o.
- rst_i asserted during WAIT -> dev_req_o=0, rvalid_o=0, prio_q=0, deny_cnt_o=0 immediately. The next host0 request is granted normally.
